// File: rtl/rpi_vga_bridge.sv
// Raspberry Pi DPI-style colour/sync to 12-bit VGA bridge with synchronisers and output register.
// Optional hsync loss-of-signal watchdog and output blanking built when RPI_VGA_LOS_EN is defined.
module rpi_vga_bridge #(
  parameter int IN_BITS     = 1,
  parameter int SYNC_STAGES = 2,
  parameter int LOS_CYCLES  = 4096,
  parameter bit HS_INV      = 1'b0,
  parameter bit VS_INV      = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rpi_h_sync,
  input  logic               rpi_v_sync,
  input  logic [IN_BITS-1:0] rpi_color,
  input  logic [11:0]        fg_rgb,
  input  logic [11:0]        bg_rgb,
  input  logic [1:0]         mode,
  output logic               h_sync,
  output logic               v_sync,
  output logic [3:0]         r_out,
  output logic [3:0]         g_out,
  output logic [3:0]         b_out,
  output logic               signal_ok,
  output logic [7:0]         frame_count
);

  localparam int SW = IN_BITS + 2;

  if ((IN_BITS != 1 && IN_BITS != 3) || SYNC_STAGES < 2 || SYNC_STAGES > 4 || LOS_CYCLES < 1)
  begin : g_bad_param
    $error("rpi_vga_bridge: illegal parameter combination");
  end

  // Syncs and colour share one packed chain so they can never skew against each other.
  logic [SYNC_STAGES-1:0][SW-1:0] sync_q, sync_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = {rpi_h_sync, rpi_v_sync, rpi_color};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  logic               hs_s, vs_s;
  logic [IN_BITS-1:0] col_s;
  assign {hs_s, vs_s, col_s} = sync_q[SYNC_STAGES-1];

  logic vs_prev_q, vs_prev_d;
  logic vs_rise;
  assign vs_prev_d = vs_s;
  assign vs_rise   = vs_s & ~vs_prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) vs_prev_q <= 1'b0;
    else        vs_prev_q <= vs_prev_d;
  end

  logic sig_ok_now;

`ifdef RPI_VGA_LOS_EN
  localparam int             CW      = $clog2(LOS_CYCLES + 1);
  localparam logic [CW-1:0]  LOS_MAX = CW'(LOS_CYCLES);

  logic          hs_prev_q, hs_prev_d;
  logic          hs_rise;
  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic          signal_ok_q, signal_ok_d;

  assign hs_prev_d = hs_s;
  assign hs_rise   = hs_s & ~hs_prev_q;

  // An edge clears the counter even on the cycle it would saturate, so the edge wins.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (hs_rise)                  wd_cnt_d = '0;
    else if (wd_cnt_q != LOS_MAX) wd_cnt_d = wd_cnt_q + 1'b1;
    signal_ok_d = (wd_cnt_d < LOS_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_prev_q   <= 1'b0;
      wd_cnt_q    <= LOS_MAX;
      signal_ok_q <= 1'b0;
    end else begin
      hs_prev_q   <= hs_prev_d;
      wd_cnt_q    <= wd_cnt_d;
      signal_ok_q <= signal_ok_d;
    end
  end

  // Blank with the same-cycle decision so signal_ok and the outputs change together.
  assign sig_ok_now = signal_ok_d;
  assign signal_ok  = signal_ok_q;
`else
  assign sig_ok_now = 1'b1;
  assign signal_ok  = 1'b1;
`endif

  logic [11:0] base_rgb;

  if (IN_BITS == 1) begin : g_mono
    assign base_rgb = col_s[0] ? fg_rgb : bg_rgb;
  end else begin : g_rgb
    assign base_rgb = {{4{col_s[IN_BITS-1]}}, {4{col_s[1]}}, {4{col_s[0]}}};
  end

  logic [11:0] mode_rgb;

  always_comb begin
    mode_rgb = base_rgb;
    case (mode)
      2'b00:   mode_rgb = base_rgb;
      2'b01:   mode_rgb = ~base_rgb;
      2'b10:   mode_rgb = bg_rgb;
      default: mode_rgb = fg_rgb;
    endcase
  end

  logic [11:0] rgb_q, rgb_d;
  logic        h_sync_q, h_sync_d;
  logic        v_sync_q, v_sync_d;
  logic [7:0]  frame_count_q, frame_count_d;

  always_comb begin
    rgb_d         = '0;
    h_sync_d      = HS_INV;
    v_sync_d      = VS_INV;
    frame_count_d = frame_count_q;
    if (sig_ok_now) begin
      rgb_d    = mode_rgb;
      h_sync_d = hs_s ^ HS_INV;
      v_sync_d = vs_s ^ VS_INV;
    end
    if (vs_rise) frame_count_d = frame_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_q         <= '0;
      h_sync_q      <= HS_INV;
      v_sync_q      <= VS_INV;
      frame_count_q <= '0;
    end else begin
      rgb_q         <= rgb_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign r_out       = rgb_q[11:8];
  assign g_out       = rgb_q[7:4];
  assign b_out       = rgb_q[3:0];
  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_rpi_vga_bridge.sv
// Directed bench for rpi_vga_bridge: mono, RGB and inverted-sync instances on shared stimulus.
module tb_rpi_vga_bridge;

`ifdef RPI_VGA_LOS_EN
  localparam bit LOS_EN = 1'b1;
`else
  localparam bit LOS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hs, vs;
  logic [0:0]  c1;
  logic [2:0]  c3;
  logic [11:0] fg, bg;
  logic [1:0]  mode;

  logic       h1, v1, ok1, h3, v3, ok3, hi, vi, oki;
  logic [3:0] r1, g1, b1, r3, g3, b3, ri, gi, bi;
  logic [7:0] fc1, fc3, fci;

  always #5 clk = ~clk;

  rpi_vga_bridge #(.IN_BITS(1), .SYNC_STAGES(2), .LOS_CYCLES(16), .HS_INV(1'b0), .VS_INV(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .rpi_h_sync(hs), .rpi_v_sync(vs), .rpi_color(c1),
    .fg_rgb(fg), .bg_rgb(bg), .mode(mode), .h_sync(h1), .v_sync(v1),
    .r_out(r1), .g_out(g1), .b_out(b1), .signal_ok(ok1), .frame_count(fc1));

  rpi_vga_bridge #(.IN_BITS(3), .SYNC_STAGES(2), .LOS_CYCLES(16), .HS_INV(1'b0), .VS_INV(1'b0)) u3 (
    .clk(clk), .rst_n(rst_n), .rpi_h_sync(hs), .rpi_v_sync(vs), .rpi_color(c3),
    .fg_rgb(fg), .bg_rgb(bg), .mode(mode), .h_sync(h3), .v_sync(v3),
    .r_out(r3), .g_out(g3), .b_out(b3), .signal_ok(ok3), .frame_count(fc3));

  rpi_vga_bridge #(.IN_BITS(1), .SYNC_STAGES(2), .LOS_CYCLES(16), .HS_INV(1'b1), .VS_INV(1'b1)) ui (
    .clk(clk), .rst_n(rst_n), .rpi_h_sync(hs), .rpi_v_sync(vs), .rpi_color(c1),
    .fg_rgb(fg), .bg_rgb(bg), .mode(mode), .h_sync(hi), .v_sync(vi),
    .r_out(ri), .g_out(gi), .b_out(bi), .signal_ok(oki), .frame_count(fci));

  typedef struct {
    logic [1:0]  mode;
    logic        c1;
    logic [2:0]  c3;
    logic [11:0] fg, bg, exp1, exp3;
  } vec_t;

  vec_t tv[7];
  int   nvec = 0;
  int   nerr = 0;
  int   ph = 0;
  bit   hs_run = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance n clocks; inputs change on the falling edge, hsync toggles with period 8 when running.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      if (hs_run) begin
        hs = ((ph % 8) >= 4);
        ph++;
      end
    end
  endtask

  task automatic vs_pulses(input int n);
    repeat (n) begin
      vs = 1'b1; cyc(1);
      vs = 1'b0; cyc(1);
    end
  endtask

  initial begin
    tv[0] = '{2'b00, 1'b1, 3'b101, 12'hF80, 12'h00F, 12'hF80, 12'hF0F};
    tv[1] = '{2'b00, 1'b0, 3'b010, 12'hF80, 12'h00F, 12'h00F, 12'h0F0};
    tv[2] = '{2'b01, 1'b1, 3'b101, 12'hF80, 12'h00F, 12'h07F, 12'h0F0};
    tv[3] = '{2'b10, 1'b1, 3'b101, 12'hF80, 12'h123, 12'h123, 12'h123};
    tv[4] = '{2'b11, 1'b0, 3'b000, 12'hABC, 12'h123, 12'hABC, 12'hABC};
    tv[5] = '{2'b01, 1'b0, 3'b111, 12'hF80, 12'h00F, 12'hFF0, 12'h000};
    tv[6] = '{2'b00, 1'b1, 3'b110, 12'h5A3, 12'h00F, 12'h5A3, 12'hFF0};

    rst_n = 1'b0; hs = 1'b0; vs = 1'b0; c1 = 1'b0; c3 = 3'b000;
    fg = 12'hF80; bg = 12'h00F; mode = 2'b00;
    @(negedge clk);
    cyc(2);
    chk("rst_rgb",   {r1, g1, b1}, 12'h000);
    chk("rst_hs",    h1, 1'b0);
    chk("rst_vs",    v1, 1'b0);
    chk("rst_fc",    fc1, 8'd0);
    chk("rst_ok",    ok1, !LOS_EN);
    chk("rst_hs_inv", hi, 1'b1);
    chk("rst_vs_inv", vi, 1'b1);

    // Released, no hsync edge yet.
    rst_n = 1'b1;
    cyc(5);
    chk("pre_edge_hs_inv", hi, 1'b1);
    chk("pre_edge_vs_inv", vi, 1'b1);
    chk("pre_edge_ok",     oki, !LOS_EN);
    chk("pre_edge_rgb",    {r1, g1, b1}, LOS_EN ? 12'h000 : 12'h00F);

    hs = 1'b1;
    cyc(3);
    chk("first_edge_hs_inv", hi, 1'b0);
    chk("first_edge_ok",     oki, 1'b1);
    chk("first_edge_hs",     h1, 1'b1);
    chk("first_edge_rgb",    {r1, g1, b1}, 12'h00F);
    vs = 1'b1;
    cyc(3);
    chk("vs_follow_inv", vi, 1'b0);
    chk("vs_follow",     v1, 1'b1);
    vs = 1'b0;

    hs_run = 1'b1;
    cyc(16);

    // Exact three-cycle latency with two synchroniser stages.
    c1 = 1'b0;
    cyc(4);
    c1 = 1'b1;
    cyc(2);
    chk("lat_cycle2_old", {r1, g1, b1}, 12'h00F);
    cyc(1);
    chk("lat_cycle3_new", {r1, g1, b1}, 12'hF80);
    c1 = 1'b0;
    cyc(3);
    chk("lat_back_bg", {r1, g1, b1}, 12'h00F);

    for (int i = 0; i < 7; i++) begin
      mode = tv[i].mode; c1 = tv[i].c1; c3 = tv[i].c3; fg = tv[i].fg; bg = tv[i].bg;
      cyc(3);
      chk($sformatf("vec%0d_mono", i), {r1, g1, b1}, tv[i].exp1);
      chk($sformatf("vec%0d_rgb", i),  {r3, g3, b3}, tv[i].exp3);
    end

    // Loss of signal: one final hsync pulse, then hsync held low.
    hs_run = 1'b0; hs = 1'b0; mode = 2'b00; c1 = 1'b1; fg = 12'hF80; bg = 12'h00F;
    cyc(4);
    hs = 1'b1;
    cyc(1);
    hs = 1'b0;
    cyc(17);
    chk("los_ok_before",  ok1, 1'b1);
    chk("los_rgb_before", {r1, g1, b1}, 12'hF80);
    cyc(1);
    chk("los_ok_after",   ok1, !LOS_EN);
    chk("los_rgb_after",  {r1, g1, b1}, LOS_EN ? 12'h000 : 12'hF80);
    chk("los_hs_after",   h1, 1'b0);
    chk("los_hs_inv",     hi, 1'b1);

    // Frame counter wrap over 257 vsync pulses.
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    vs_pulses(255);
    cyc(4);
    chk("fc_255", fc1, 8'd255);
    vs_pulses(1);
    cyc(4);
    chk("fc_wrap", fc1, 8'd0);
    vs_pulses(1);
    cyc(4);
    chk("fc_257", fc1, 8'd1);
    chk("fc_257_inv_inst", fci, 8'd1);

    // Reset mid-line.
    hs_run = 1'b1;
    cyc(16);
    chk("midline_rgb", {r1, g1, b1}, 12'hF80);
    rst_n = 1'b0;
    cyc(1);
    chk("mid_rst_rgb",    {r1, g1, b1}, 12'h000);
    chk("mid_rst_rgb3",   {r3, g3, b3}, 12'h000);
    chk("mid_rst_hs",     h1, 1'b0);
    chk("mid_rst_vs",     v1, 1'b0);
    chk("mid_rst_fc",     fc1, 8'd0);
    chk("mid_rst_ok",     ok1, !LOS_EN);
    chk("mid_rst_hs_inv", hi, 1'b1);
    chk("mid_rst_vs_inv", vi, 1'b1);
    rst_n = 1'b1;
    hs_run = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
